// File: rtl/pe_sched_pkg.sv
// Shared types for the PE task sequencer: FSM state encoding and the latched task descriptor.
package pe_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_LD    = 3'd1,
    S_SWITCH     = 3'd2,
    S_START      = 3'd3,
    S_RUN        = 3'd4,
    S_WAIT_DRAIN = 3'd5,
    S_ACC_SW     = 3'd6
  } pe_sched_state_t;

  typedef struct packed {
    logic [2:0] mode;
    logic [7:0] idx_cnt;
    logic [7:0] trip_cnt;
    logic       is_new;
    logic [3:0] pad_code;
    logic       cut_y;
    logic       reuse_p;
    logic       last;
  } pe_task_t;

endpackage

// File: rtl/pe_sched_bank_flag.sv
// Fill flag for one shadow bank: a loader fill sets it, a buffer switch clears it, and a fill wins a tie.
module bank_flag (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic full,
  output logic overflow
);

  logic r_full;

  always_ff @(posedge clk) begin
    if (!rst) r_full <= 1'b0;
    else      r_full <= set | (r_full & ~clr);
  end

  assign full     = r_full;
  // A fill landing on the very cycle the bank is switched away is legitimate, not an overflow.
  assign overflow = set & r_full & ~clr;

endmodule

// File: rtl/pe_sched.sv
// Task sequencer for one PE: gates descriptors on shadow-bank fill, pulses buffer switches and
// start, supervises the run with a watchdog and rotates the accumulation buffer to the drain path.
module pe_sched
  import pe_sched_pkg::*;
#(
  parameter int WD_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       task_valid,
  output logic       task_ready,
  input  logic [2:0] task_mode,
  input  logic [7:0] task_idx_cnt,
  input  logic [7:0] task_trip_cnt,
  input  logic       task_is_new,
  input  logic [3:0] task_pad_code,
  input  logic       task_cut_y,
  input  logic       task_reuse_p,
  input  logic       task_last,
  input  logic       ld_i_done,
  input  logic       ld_d_done,
  input  logic       ld_p_done,
  output logic       ld_i_free,
  output logic       ld_d_free,
  output logic       ld_p_free,
  output logic       switch_i,
  output logic       switch_d,
  output logic       switch_p,
  output logic       switch_a,
  output logic       pe_start,
  input  logic       pe_done,
  output logic [2:0] pe_mode,
  output logic [7:0] pe_idx_cnt,
  output logic [7:0] pe_trip_cnt,
  output logic       pe_is_new,
  output logic [3:0] pe_pad_code,
  output logic       pe_cut_y,
  output logic       drain_valid,
  input  logic       drain_ack,
  output logic       busy,
  output logic [1:0] err
);

  localparam logic [WD_W-1:0] WD_LAST = {{(WD_W-1){1'b1}}, 1'b0};

  pe_sched_state_t r_state, w_state_nx;
  pe_task_t        r_task;
  logic [WD_W-1:0] r_wd;
  logic            r_drain_valid;
  logic [1:0]      r_err;

  logic w_full_i, w_full_d, w_full_p;
  logic w_ovf_i, w_ovf_d, w_ovf_p;
  logic w_sw_id, w_sw_p, w_start, w_sw_a, w_idle;
  logic w_accept, w_timeout, w_banks_rdy;

  bank_flag u_flag_i (.clk(clk), .rst(rst), .set(ld_i_done), .clr(w_sw_id),
                      .full(w_full_i), .overflow(w_ovf_i));
  bank_flag u_flag_d (.clk(clk), .rst(rst), .set(ld_d_done), .clr(w_sw_id),
                      .full(w_full_d), .overflow(w_ovf_d));
  bank_flag u_flag_p (.clk(clk), .rst(rst), .set(ld_p_done), .clr(w_sw_p),
                      .full(w_full_p), .overflow(w_ovf_p));

  assign w_accept    = task_valid & w_idle;
  assign w_banks_rdy = w_full_i & w_full_d & (w_full_p | r_task.reuse_p);
  // The counter reaches all-ones on the edge that ends this cycle, so the timeout is taken there.
  assign w_timeout   = (r_state == S_RUN) & ~pe_done & (r_wd == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:       if (task_valid) w_state_nx = S_WAIT_LD;
      S_WAIT_LD:    if (w_banks_rdy) w_state_nx = S_SWITCH;
      S_SWITCH:     w_state_nx = S_START;
      S_START:      w_state_nx = S_RUN;
      S_RUN: begin
        if (pe_done) begin
          if (!r_task.last)                      w_state_nx = S_IDLE;
          else if (r_drain_valid && !drain_ack)  w_state_nx = S_WAIT_DRAIN;
          else                                   w_state_nx = S_ACC_SW;
        end else if (w_timeout) begin
          w_state_nx = S_IDLE;
        end
      end
      S_WAIT_DRAIN: if (!r_drain_valid || drain_ack) w_state_nx = S_ACC_SW;
      S_ACC_SW:     w_state_nx = S_IDLE;
      default:      w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_idle  = 1'b0;
    w_sw_id = 1'b0;
    w_sw_p  = 1'b0;
    w_start = 1'b0;
    w_sw_a  = 1'b0;
    case (r_state)
      S_IDLE:   w_idle  = 1'b1;
      S_SWITCH: begin
        w_sw_id = 1'b1;
        w_sw_p  = ~r_task.reuse_p;
      end
      S_START:  w_start = 1'b1;
      S_ACC_SW: w_sw_a  = 1'b1;
      default:  ;
    endcase
  end

  // Descriptor, watchdog, drain handshake and sticky error bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_task        <= '0;
      r_wd          <= '0;
      r_drain_valid <= 1'b0;
      r_err         <= 2'b00;
    end else begin
      if (w_accept) begin
        r_task <= '{mode: task_mode, idx_cnt: task_idx_cnt, trip_cnt: task_trip_cnt,
                    is_new: task_is_new, pad_code: task_pad_code, cut_y: task_cut_y,
                    reuse_p: task_reuse_p, last: task_last};
      end
      if (r_state == S_START)    r_wd <= '0;
      else if (r_state == S_RUN) r_wd <= r_wd + 1'b1;
      if (w_sw_a)         r_drain_valid <= 1'b1;
      else if (drain_ack) r_drain_valid <= 1'b0;
      r_err <= r_err | {w_timeout, w_ovf_i | w_ovf_d | w_ovf_p};
    end
  end

  assign task_ready  = w_idle;
  assign busy        = ~w_idle;
  assign ld_i_free   = ~w_full_i;
  assign ld_d_free   = ~w_full_d;
  assign ld_p_free   = ~w_full_p;
  assign switch_i    = w_sw_id;
  assign switch_d    = w_sw_id;
  assign switch_p    = w_sw_p;
  assign switch_a    = w_sw_a;
  assign pe_start    = w_start;
  assign pe_mode     = r_task.mode;
  assign pe_idx_cnt  = r_task.idx_cnt;
  assign pe_trip_cnt = r_task.trip_cnt;
  assign pe_is_new   = r_task.is_new;
  assign pe_pad_code = r_task.pad_code;
  assign pe_cut_y    = r_task.cut_y;
  assign drain_valid = r_drain_valid;
  assign err         = r_err;

endmodule

// File: tb/tb_pe_sched.sv
// Directed bench for pe_sched: drives on the falling edge, checks post-edge state with immediate assertions.
module tb_pe_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       task_valid, task_ready;
  logic [2:0] task_mode;
  logic [7:0] task_idx_cnt, task_trip_cnt;
  logic       task_is_new, task_cut_y, task_reuse_p, task_last;
  logic [3:0] task_pad_code;
  logic       ld_i_done, ld_d_done, ld_p_done;
  logic       ld_i_free, ld_d_free, ld_p_free;
  logic       switch_i, switch_d, switch_p, switch_a;
  logic       pe_start, pe_done;
  logic [2:0] pe_mode;
  logic [7:0] pe_idx_cnt, pe_trip_cnt;
  logic       pe_is_new, pe_cut_y;
  logic [3:0] pe_pad_code;
  logic       drain_valid, drain_ack, busy;
  logic [1:0] err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_sched #(.WD_W(4)) dut (
    .clk(clk), .rst(rst),
    .task_valid(task_valid), .task_ready(task_ready),
    .task_mode(task_mode), .task_idx_cnt(task_idx_cnt), .task_trip_cnt(task_trip_cnt),
    .task_is_new(task_is_new), .task_pad_code(task_pad_code), .task_cut_y(task_cut_y),
    .task_reuse_p(task_reuse_p), .task_last(task_last),
    .ld_i_done(ld_i_done), .ld_d_done(ld_d_done), .ld_p_done(ld_p_done),
    .ld_i_free(ld_i_free), .ld_d_free(ld_d_free), .ld_p_free(ld_p_free),
    .switch_i(switch_i), .switch_d(switch_d), .switch_p(switch_p), .switch_a(switch_a),
    .pe_start(pe_start), .pe_done(pe_done),
    .pe_mode(pe_mode), .pe_idx_cnt(pe_idx_cnt), .pe_trip_cnt(pe_trip_cnt),
    .pe_is_new(pe_is_new), .pe_pad_code(pe_pad_code), .pe_cut_y(pe_cut_y),
    .drain_valid(drain_valid), .drain_ack(drain_ack), .busy(busy), .err(err)
  );

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic i, input logic d, input logic p);
    ld_i_done = i; ld_d_done = d; ld_p_done = p;
    step();
    ld_i_done = 1'b0; ld_d_done = 1'b0; ld_p_done = 1'b0;
  endtask

  // Presents a descriptor for one edge while IDLE; returns in cycle T+1.
  task automatic accept(input logic [2:0] m, input logic [7:0] idx, input logic [7:0] trip,
                        input logic reuse, input logic last);
    task_mode = m; task_idx_cnt = idx; task_trip_cnt = trip; task_is_new = 1'b1;
    task_pad_code = 4'h3; task_cut_y = 1'b1; task_reuse_p = reuse; task_last = last;
    task_valid = 1'b1;
    step();
    task_valid = 1'b0;
  endtask

  task automatic done_pulse();
    pe_done = 1'b1;
    step();
    pe_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL bench_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; task_valid = 1'b0; task_mode = '0; task_idx_cnt = '0; task_trip_cnt = '0;
    task_is_new = 1'b0; task_pad_code = '0; task_cut_y = 1'b0; task_reuse_p = 1'b0;
    task_last = 1'b0; ld_i_done = 1'b0; ld_d_done = 1'b0; ld_p_done = 1'b0;
    pe_done = 1'b0; drain_ack = 1'b0;

    // Reset
    step(3);
    chk("rst_ready", task_ready, 1);
    chk("rst_free", {ld_i_free, ld_d_free, ld_p_free}, 3'b111);
    chk("rst_pulses", {switch_i, switch_d, switch_p, switch_a, pe_start}, 5'b0);
    chk("rst_err", err, 2'b00);
    chk("rst_busy_dv", {busy, drain_valid}, 2'b00);
    chk("rst_cfg", {pe_mode, pe_idx_cnt, pe_trip_cnt}, 19'd0);
    rst = 1'b1;
    step();

    // Ready path, all banks preloaded
    load(1, 1, 1);
    chk("pre_free", {ld_i_free, ld_d_free, ld_p_free}, 3'b000);
    accept(3'd2, 8'd9, 8'd4, 1'b0, 1'b0);
    chk("t1_waitld", {busy, task_ready, switch_i, pe_start}, 4'b1000);
    step();
    chk("t2_switch", {switch_i, switch_d, switch_p, switch_a, pe_start}, 5'b11100);
    step();
    chk("t3_start", {switch_i, switch_d, switch_p, pe_start}, 4'b0001);
    chk("t3_cfg", {pe_mode, pe_idx_cnt, pe_trip_cnt}, {3'd2, 8'd9, 8'd4});
    chk("t3_cfg2", {pe_is_new, pe_pad_code, pe_cut_y}, {1'b1, 4'h3, 1'b1});
    chk("t3_free", {ld_i_free, ld_d_free, ld_p_free}, 3'b111);
    task_idx_cnt = 8'd55;
    step();
    chk("run_hold", {pe_start, pe_idx_cnt}, {1'b0, 8'd9});
    done_pulse();
    chk("done_idle", {task_ready, busy, switch_a, drain_valid}, 4'b1000);
    chk("done_cfg", pe_idx_cnt, 8'd9);

    // pe_done outside RUN is ignored
    done_pulse();
    chk("stray_done", {task_ready, switch_a, busy}, 3'b100);

    // Late parameter loader
    load(1, 1, 0);
    accept(3'd1, 8'd5, 8'd2, 1'b0, 1'b0);
    step(9);
    chk("late_wait", {busy, switch_i, switch_p, pe_start}, 4'b1000);
    ld_p_done = 1'b1;
    step();
    ld_p_done = 1'b0;
    chk("late_flag", {ld_p_free, switch_i, busy}, 3'b001);
    step();
    chk("late_switch", {switch_i, switch_d, switch_p}, 3'b111);
    step();
    chk("late_start", pe_start, 1);
    step();
    done_pulse();
    chk("late_idle", task_ready, 1);

    // Parameter bank reuse: no wait for p, no switch_p
    load(1, 1, 0);
    accept(3'd1, 8'd6, 8'd2, 1'b1, 1'b0);
    step();
    chk("reuse_switch", {switch_i, switch_d, switch_p}, 3'b110);
    step();
    chk("reuse_start", pe_start, 1);
    step();
    done_pulse();
    chk("reuse_idle", task_ready, 1);

    // Last task, then second last task stalls on pending drain
    load(1, 1, 1);
    accept(3'd4, 8'd7, 8'd3, 1'b0, 1'b1);
    step(3);
    done_pulse();
    chk("last1_swa", {switch_a, task_ready, drain_valid}, 3'b100);
    step();
    chk("last1_idle", {switch_a, task_ready, drain_valid}, 3'b011);
    load(1, 1, 1);
    accept(3'd4, 8'd8, 8'd3, 1'b0, 1'b1);
    step(3);
    done_pulse();
    chk("last2_stall", {busy, switch_a, drain_valid}, 3'b101);
    step(2);
    chk("last2_stall2", {busy, switch_a, drain_valid, task_ready}, 4'b1010);
    drain_ack = 1'b1;
    step();
    drain_ack = 1'b0;
    chk("last2_swa", {switch_a, drain_valid}, 2'b10);
    step();
    chk("last2_idle", {task_ready, drain_valid, switch_a}, 3'b110);
    drain_ack = 1'b1;
    step();
    drain_ack = 1'b0;
    chk("drain_clear", drain_valid, 0);

    // Loader overflow on d
    load(0, 1, 0);
    chk("ovf_first", {ld_d_free, err}, {1'b0, 2'b00});
    load(0, 1, 0);
    chk("ovf_second", {ld_d_free, err}, {1'b0, 2'b01});
    // Fill of d in the SWITCH cycle survives the switch
    load(1, 0, 1);
    accept(3'd1, 8'd1, 8'd1, 1'b0, 1'b0);
    step();
    ld_d_done = 1'b1;
    chk("sim_switch", switch_d, 1);
    step();
    ld_d_done = 1'b0;
    chk("sim_free", {ld_i_free, ld_d_free, ld_p_free, pe_start}, 4'b1011);

    // Reset mid-task: run aborts, flags and errors clear
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_state", {busy, task_ready, switch_a, pe_start}, 4'b0100);
    chk("midrst_flags", {ld_i_free, ld_d_free, ld_p_free, err}, 5'b11100);
    chk("midrst_cfg", pe_idx_cnt, 8'd0);

    // Watchdog with WD_W=4: 15 RUN cycles without pe_done
    load(1, 1, 1);
    accept(3'd3, 8'd2, 8'd2, 1'b0, 1'b1);
    step(2);
    chk("wd_start", pe_start, 1);
    step(15);
    chk("wd_run14", {busy, err}, 3'b100);
    step();
    chk("wd_timeout", {busy, task_ready, err, switch_a}, 5'b01100);
    step();
    chk("wd_no_swa", {switch_a, drain_valid, err}, 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
